i2c_reg_bank: RTL and testbench



---
 rtl/i2c_reg_bank.sv | 115 +++++++++++
 tb/tb_i2c_reg_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave byte interface: control regs with write strobes,
// status regs (sticky W1C when REGIF_STICKY_STAT_EN is defined, else live-registered), version + scratch at 0xFC-0xFF.
`timescale 1ns/1ps

`ifndef FW_BUILD_VERSION
`define FW_BUILD_VERSION 8'h2A
`endif
`ifndef FW_MINOR_VERSION
`define FW_MINOR_VERSION 8'h03
`endif
`ifndef FW_MAJOR_VERSION
`define FW_MAJOR_VERSION 8'h01
`endif

module i2c_reg_bank #(
  parameter int                    NUM_CTRL   = 4,
  parameter logic [7:0]            CTRL_BASE  = 8'h00,
  parameter logic [8*NUM_CTRL-1:0] CTRL_RESET = {8*NUM_CTRL{1'b0}},
  parameter int                    NUM_STAT   = 4,
  parameter logic [7:0]            STAT_BASE  = 8'h40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              addr,
  input  logic [7:0]              dataIn,
  input  logic                    writeEn,
  output logic [7:0]              dataOut,
  output logic [8*NUM_CTRL-1:0]   ctrl_out,
  output logic [NUM_CTRL-1:0]     ctrl_wr_stb,
  input  logic [8*NUM_STAT-1:0]   stat_in,
  output logic                    stat_pend
);

  localparam int CtrlLast = int'(CTRL_BASE) + NUM_CTRL - 1;
  localparam int StatLast = int'(STAT_BASE) + NUM_STAT - 1;
  localparam bit CfgBad = (NUM_CTRL < 1) || (NUM_CTRL > 64) || (NUM_STAT < 1) || (NUM_STAT > 64) ||
                          (CtrlLast > 251) || (StatLast > 251) ||
                          !((CtrlLast < int'(STAT_BASE)) || (StatLast < int'(CTRL_BASE)));

  generate
    if (CfgBad) begin : gCfgError
      $error("i2c_reg_bank: control/status ranges overlap, wrap, or hit 0xFC-0xFF");
    end
  endgenerate

  logic [7:0]          ctrlReg [NUM_CTRL];
  logic [7:0]          statReg [NUM_STAT];
  logic [NUM_CTRL-1:0] ctrlHit;
  logic [NUM_CTRL-1:0] ctrlStbReg;
  logic [NUM_STAT-1:0] statHit;
  logic [NUM_STAT-1:0] statNonZero;
  logic [7:0]          scratchReg;
  logic [7:0]          dataOutReg;
  logic [7:0]          readData;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : gCtrl
      assign ctrlHit[gi]            = (addr == 8'(int'(CTRL_BASE) + gi));
      assign ctrl_out[8*gi +: 8]    = ctrlReg[gi];
    end
    for (gi = 0; gi < NUM_STAT; gi++) begin : gStat
      assign statHit[gi]     = (addr == 8'(int'(STAT_BASE) + gi));
      assign statNonZero[gi] = |statReg[gi];
    end
  endgenerate

  assign stat_pend   = |statNonZero;
  assign ctrl_wr_stb = ctrlStbReg;
  assign dataOut     = dataOutReg;

  // Decoded ranges never overlap, so at most one source matches.
  always_comb begin
    readData = 8'h00;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (ctrlHit[i]) readData = ctrlReg[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (statHit[j]) readData = statReg[j];
    end
    case (addr)
      8'hFC:   readData = `FW_BUILD_VERSION;
      8'hFD:   readData = `FW_MINOR_VERSION;
      8'hFE:   readData = `FW_MAJOR_VERSION;
      8'hFF:   readData = scratchReg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrlReg[i] <= CTRL_RESET[8*i +: 8];
      for (int j = 0; j < NUM_STAT; j++) statReg[j] <= 8'h00;
      ctrlStbReg <= '0;
      scratchReg <= 8'h00;
      dataOutReg <= 8'h00;
    end else begin
      dataOutReg <= readData;
      ctrlStbReg <= writeEn ? ctrlHit : '0;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (writeEn && ctrlHit[i]) ctrlReg[i] <= dataIn;
      end
      for (int j = 0; j < NUM_STAT; j++) begin
`ifdef REGIF_STICKY_STAT_EN
        // New events are ORed in after the clear so a simultaneous set wins.
        statReg[j] <= (statReg[j] & ~((writeEn && statHit[j]) ? dataIn : 8'h00)) | stat_in[8*j +: 8];
`else
        statReg[j] <= stat_in[8*j +: 8];
`endif
      end
      if (writeEn && (addr == 8'hFF)) scratchReg <= dataIn;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomised + directed bench for i2c_reg_bank against an array-based reference model.
`timescale 1ns/1ps

`ifndef FW_BUILD_VERSION
`define FW_BUILD_VERSION 8'h2A
`endif
`ifndef FW_MINOR_VERSION
`define FW_MINOR_VERSION 8'h03
`endif
`ifndef FW_MAJOR_VERSION
`define FW_MAJOR_VERSION 8'h01
`endif

module tb_i2c_reg_bank;

  localparam int NC = 4;
  localparam int NS = 4;
  localparam int CB = 8'h00;
  localparam int SB = 8'h40;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        addr;
  logic [7:0]        dataIn;
  logic              writeEn;
  logic [7:0]        dataOut;
  logic [8*NC-1:0]   ctrl_out;
  logic [NC-1:0]     ctrl_wr_stb;
  logic [8*NS-1:0]   stat_in;
  logic              stat_pend;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  i2c_reg_bank #(
    .NUM_CTRL(NC), .CTRL_BASE(8'h00), .CTRL_RESET(32'h0000_A500),
    .NUM_STAT(NS), .STAT_BASE(8'h40)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .dataIn(dataIn), .writeEn(writeEn),
    .dataOut(dataOut), .ctrl_out(ctrl_out), .ctrl_wr_stb(ctrl_wr_stb),
    .stat_in(stat_in), .stat_pend(stat_pend)
  );

  always #5 clk = ~clk;

  // Reference model: register contents as plain arrays.
  logic [7:0]    mCtrl [NC];
  logic [7:0]    mStat [NS];
  logic [7:0]    mScratch;
  logic [7:0]    mDout;
  logic [NC-1:0] mStb;

  function automatic logic [7:0] mRead(input logic [7:0] a);
    if (a >= CB && a < CB + NC) return mCtrl[a - CB];
    if (a >= SB && a < SB + NS) return mStat[a - SB];
    if (a == 8'hFC) return `FW_BUILD_VERSION;
    if (a == 8'hFD) return `FW_MINOR_VERSION;
    if (a == 8'hFE) return `FW_MAJOR_VERSION;
    if (a == 8'hFF) return mScratch;
    return 8'h00;
  endfunction

  function automatic logic [8*NC-1:0] mCtrlPacked();
    logic [8*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[8*i +: 8] = mCtrl[i];
    return v;
  endfunction

  function automatic logic mPend();
    logic p;
    p = 1'b0;
    for (int j = 0; j < NS; j++) p = p | (mStat[j] != 8'h00);
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) mCtrl[i] <= (i == 1) ? 8'hA5 : 8'h00;
      for (int j = 0; j < NS; j++) mStat[j] <= 8'h00;
      mScratch <= 8'h00;
      mDout    <= 8'h00;
      mStb     <= '0;
    end else begin
      mDout <= mRead(addr);
      mStb  <= '0;
      for (int j = 0; j < NS; j++) begin
`ifdef REGIF_STICKY_STAT_EN
        mStat[j] <= (mStat[j] & ~((writeEn && addr == SB + j) ? dataIn : 8'h00)) | stat_in[8*j +: 8];
`else
        mStat[j] <= stat_in[8*j +: 8];
`endif
      end
      if (writeEn) begin
        if (addr >= CB && addr < CB + NC) begin
          mCtrl[addr - CB] <= dataIn;
          mStb <= NC'(1) << (addr - CB);
        end else if (addr == 8'hFF) begin
          mScratch <= dataIn;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      cmp("dataOut", 32'(dataOut), 32'(mDout));
      cmp("ctrl_out", 32'(ctrl_out), 32'(mCtrlPacked()));
      cmp("ctrl_wr_stb", 32'(ctrl_wr_stb), 32'(mStb));
      cmp("stat_pend", 32'(stat_pend), 32'(mPend()));
    end
  end

  task automatic step(input logic [7:0] a, input logic [7:0] d, input logic we,
                      input logic [8*NS-1:0] s, input logic r);
    addr = a; dataIn = d; writeEn = we; stat_in = s; rst = r;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%0b we=%0b addr=%02h din=%02h stat_in=%08h -> dout=%02h ctrl=%08h stb=%04b pend=%0b",
             $time, r, we, a, d, s, dataOut, ctrl_out, ctrl_wr_stb, stat_pend);
  endtask

  initial begin
    logic [7:0]      ra;
    logic [8*NS-1:0] rs;
    int              pick;

    addr = 8'h00; dataIn = 8'h00; writeEn = 1'b0; stat_in = '0; rst = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    step(8'h00, 8'h00, 1'b0, '0, 1'b1);
    cmp("rst_dataOut", 32'(dataOut), 32'h00);
    cmp("rst_ctrl_out", 32'(ctrl_out), 32'h0000_A500);
    cmp("rst_stb", 32'(ctrl_wr_stb), 32'h0);
    cmp("rst_pend", 32'(stat_pend), 32'h0);

    step(8'hFC, 8'h00, 1'b0, '0, 1'b0);
    cmp("ver_build", 32'(dataOut), 32'h2A);
    step(8'hFD, 8'h00, 1'b0, '0, 1'b0);
    cmp("ver_minor", 32'(dataOut), 32'h03);
    step(8'hFE, 8'h00, 1'b0, '0, 1'b0);
    cmp("ver_major", 32'(dataOut), 32'h01);

    step(8'h02, 8'h3C, 1'b1, '0, 1'b0);
    cmp("ctrl2_write", 32'(ctrl_out), 32'h003C_A500);
    cmp("ctrl2_stb", 32'(ctrl_wr_stb), 32'b0100);
    step(8'h02, 8'h00, 1'b0, '0, 1'b0);
    cmp("ctrl2_read", 32'(dataOut), 32'h3C);
    cmp("ctrl2_stb_off", 32'(ctrl_wr_stb), 32'h0);

    step(8'h80, 8'h00, 1'b0, '0, 1'b0);
    cmp("unmapped_read", 32'(dataOut), 32'h00);
    step(8'h80, 8'h55, 1'b1, '0, 1'b0);
    cmp("unmapped_stb", 32'(ctrl_wr_stb), 32'h0);
    cmp("unmapped_ctrl", 32'(ctrl_out), 32'h003C_A500);

    step(8'hFF, 8'h5A, 1'b1, '0, 1'b0);
    step(8'hFF, 8'h00, 1'b0, '0, 1'b0);
    cmp("scratch_read", 32'(dataOut), 32'h5A);

    step(8'h03, 8'h77, 1'b1, '0, 1'b0);
    cmp("same_cycle_old", 32'(dataOut), 32'h00);

    step(8'h40, 8'h00, 1'b0, 32'h0000_0081, 1'b0);
    cmp("stat_pend_set", 32'(stat_pend), 32'h1);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("stat0_read", 32'(dataOut), 32'h81);
`ifdef REGIF_STICKY_STAT_EN
    step(8'h40, 8'h01, 1'b1, '0, 1'b0);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("w1c_bit0", 32'(dataOut), 32'h80);
    step(8'h40, 8'h80, 1'b1, 32'h0000_0080, 1'b0);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("set_wins", 32'(dataOut), 32'h80);
    cmp("set_wins_pend", 32'(stat_pend), 32'h1);
    step(8'h40, 8'h80, 1'b1, '0, 1'b0);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("w1c_all", 32'(dataOut), 32'h00);
    cmp("pend_clear", 32'(stat_pend), 32'h0);
`else
    step(8'h40, 8'h00, 1'b0, 32'h0000_000F, 1'b0);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("live_0F", 32'(dataOut), 32'h0F);
    step(8'h40, 8'hFF, 1'b1, 32'h0000_000F, 1'b0);
    step(8'h40, 8'hFF, 1'b1, 32'h0000_000F, 1'b0);
    cmp("live_wr_ignored", 32'(dataOut), 32'h0F);
    cmp("live_pend", 32'(stat_pend), 32'h1);
    step(8'h40, 8'h00, 1'b0, '0, 1'b0);
    cmp("live_pend_fall", 32'(stat_pend), 32'h0);
`endif

    step(8'h41, 8'h00, 1'b0, 32'h0000_0400, 1'b0);
    step(8'h00, 8'h99, 1'b1, 32'h0000_0400, 1'b1);
    cmp("rstwr_ctrl", 32'(ctrl_out), 32'h0000_A500);
    cmp("rstwr_stb", 32'(ctrl_wr_stb), 32'h0);
    cmp("rstwr_dout", 32'(dataOut), 32'h00);
    cmp("rstwr_pend", 32'(stat_pend), 32'h0);

    step(8'h01, 8'h11, 1'b1, '0, 1'b0);
    cmp("stb1", 32'(ctrl_wr_stb), 32'b0010);
    step(8'h00, 8'h00, 1'b0, '0, 1'b1);
    cmp("stb_rst_clear", 32'(ctrl_wr_stb), 32'h0);
    cmp("ctrl1_rst", 32'(ctrl_out[15:8]), 32'hA5);

    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 3: ra = 8'($urandom_range(0, 4));
        4, 5:       ra = 8'(8'h3F + $urandom_range(0, 5));
        6:          ra = 8'(8'hFC + $urandom_range(0, 3));
        7:          ra = 8'h80;
        default:    ra = 8'($urandom);
      endcase
      for (int j = 0; j < NS; j++)
        rs[8*j +: 8] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      step(ra, 8'($urandom), 1'($urandom_range(0, 1)), rs, ($urandom_range(0, 99) == 0));
    end

    step(8'h00, 8'h00, 1'b0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
